// File: rtl/uart_core_fifo_if.sv
// Ready/valid word streams between the UART core and its byte-stream user.
// Modport slave is the UART side; master is the datapath side.
interface uart_core_fifo_if #(parameter int DATA_BITS = 8);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output tx_data, tx_valid, rx_ready,
                    input  tx_ready, rx_data, rx_valid);
    modport slave  (input  tx_data, tx_valid, rx_ready,
                    output tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/uart_core_fifo.sv
// Full-duplex UART with configurable framing, TX/RX FIFOs and sticky error flags.
// The TX line and busy flag are registered one cycle behind the TX FSM state.
module uart_core_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

module uart_core_fifo #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              tx,
    output logic              tx_busy,
    output logic              rx_frame_err,
    output logic              rx_parity_err,
    output logic              rx_overrun,
    input  logic              err_clr,
    uart_core_fifo_if.slave   bus
);
    localparam int CW = $clog2(STOP_BITS*CLK_DIV) + 1;
    localparam int BW = $clog2(DATA_BITS) + 1;
    localparam logic ODD = (PARITY == 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    // ---------------- TX ----------------
    tx_state_t            tx_state, tx_state_n;
    logic [CW-1:0]        tx_cnt, tx_cnt_n;
    logic [BW-1:0]        tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_n, tx_head;
    logic                 tx_par, tx_par_n, tx_pop, tx_empty, tx_full, tx_line, tx_act;

    assign bus.tx_ready = !tx_full;

    uart_core_fifo_buf #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk, .rst, .push(bus.tx_valid && bus.tx_ready), .pop(tx_pop),
        .wdata(bus.tx_data), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
            tx_par   <= tx_par_n;
            tx       <= tx_line;
            tx_busy  <= tx_act;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + CW'(1);
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        tx_par_n   = tx_par;
        tx_pop     = 1'b0;
        tx_line    = 1'b1;
        tx_act     = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                tx_act   = 1'b0;
                tx_cnt_n = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_sh_n    = tx_head;
                    tx_par_n   = (^tx_head) ^ ODD;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                tx_line = 1'b0;
                if (tx_cnt == CW'(CLK_DIV-1)) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                tx_line = tx_sh[0];
                if (tx_cnt == CW'(CLK_DIV-1)) begin
                    tx_cnt_n = '0;
                    tx_sh_n  = tx_sh >> 1;
                    tx_bit_n = tx_bit + BW'(1);
                    if (tx_bit == BW'(DATA_BITS-1))
                        tx_state_n = (PARITY != 0) ? TX_PARITY : TX_STOP;
                end
            end
            TX_PARITY: begin
                tx_line = tx_par;
                if (tx_cnt == CW'(CLK_DIV-1)) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt == CW'(STOP_BITS*CLK_DIV-1)) begin
                    tx_cnt_n = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_sh_n    = tx_head;
                        tx_par_n   = (^tx_head) ^ ODD;
                        tx_state_n = TX_START;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // ---------------- RX ----------------
    rx_state_t            rx_state, rx_state_n;
    logic [CW-1:0]        rx_cnt, rx_cnt_n;
    logic [BW-1:0]        rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
    logic                 rx_meta, rx_s, rx_perr, rx_perr_n, rx_wr, rx_wr_n;
    logic                 set_fe, set_pe, set_ov, rx_full, rx_empty, rx_pop;

    assign rx_pop       = bus.rx_valid && bus.rx_ready;
    assign bus.rx_valid = !rx_empty;
    assign set_ov       = rx_wr && rx_full && !rx_pop;

    uart_core_fifo_buf #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk, .rst, .push(rx_wr), .pop(rx_pop),
        .wdata(rx_sh), .rdata(bus.rx_data), .full(rx_full), .empty(rx_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta       <= 1'b1;
            rx_s          <= 1'b1;
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_sh         <= '0;
            rx_perr       <= 1'b0;
            rx_wr         <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_meta       <= rx;
            rx_s          <= rx_meta;
            rx_state      <= rx_state_n;
            rx_cnt        <= rx_cnt_n;
            rx_bit        <= rx_bit_n;
            rx_sh         <= rx_sh_n;
            rx_perr       <= rx_perr_n;
            rx_wr         <= rx_wr_n;
            rx_frame_err  <= set_fe | (rx_frame_err  & ~err_clr);
            rx_parity_err <= set_pe | (rx_parity_err & ~err_clr);
            rx_overrun    <= set_ov | (rx_overrun    & ~err_clr);
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + CW'(1);
        rx_bit_n   = rx_bit;
        rx_sh_n    = rx_sh;
        rx_perr_n  = rx_perr;
        rx_wr_n    = 1'b0;
        set_fe     = 1'b0;
        set_pe     = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (!rx_s) begin
                    rx_perr_n  = 1'b0;
                    rx_state_n = RX_START;
                end
            end
            RX_START: begin
                // Mid-bit recheck rejects glitches shorter than half a bit.
                if (rx_cnt == CW'(CLK_DIV/2-1)) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == CW'(CLK_DIV-1)) begin
                    rx_cnt_n = '0;
                    rx_sh_n  = {rx_s, rx_sh[DATA_BITS-1:1]};
                    rx_bit_n = rx_bit + BW'(1);
                    if (rx_bit == BW'(DATA_BITS-1))
                        rx_state_n = (PARITY != 0) ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (rx_cnt == CW'(CLK_DIV-1)) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_STOP;
                    if (rx_s != ((^rx_sh) ^ ODD)) begin
                        rx_perr_n = 1'b1;
                        set_pe    = 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt == CW'(CLK_DIV-1)) begin
                    rx_cnt_n = '0;
                    if (!rx_s) begin
                        set_fe     = 1'b1;
                        rx_state_n = RX_WAIT_HIGH;
                    end else begin
                        rx_wr_n    = !rx_perr;
                        rx_state_n = RX_IDLE;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                rx_cnt_n = '0;
                if (rx_s) rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_core_fifo.sv
// Directed bench: an 8N1 instance driven from the bench and an even-parity
// instance whose tx is looped back into its own rx.
module tb_uart_core_fifo;
    localparam int CD = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic a_rx = 1'b1, a_clr = 1'b0, b_clr = 1'b0;
    logic a_tx, a_busy, a_fe, a_pe, a_ov;
    logic b_tx, b_busy, b_fe, b_pe, b_ov;
    int   checks = 0;
    int   errors = 0;
    int   b_busy_cyc = 0, b_busy_rise = 0;
    logic b_busy_d = 1'b0;

    uart_core_fifo_if #(.DATA_BITS(8)) ia ();
    uart_core_fifo_if #(.DATA_BITS(8)) ib ();

    uart_core_fifo dut_a (
        .clk(clk), .rst(rst), .rx(a_rx), .tx(a_tx), .tx_busy(a_busy),
        .rx_frame_err(a_fe), .rx_parity_err(a_pe), .rx_overrun(a_ov),
        .err_clr(a_clr), .bus(ia)
    );

    uart_core_fifo #(.PARITY(2)) dut_b (
        .clk(clk), .rst(rst), .rx(b_tx), .tx(b_tx), .tx_busy(b_busy),
        .rx_frame_err(b_fe), .rx_parity_err(b_pe), .rx_overrun(b_ov),
        .err_clr(b_clr), .bus(ib)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (b_busy) b_busy_cyc <= b_busy_cyc + 1;
        if (b_busy && !b_busy_d) b_busy_rise <= b_busy_rise + 1;
        b_busy_d <= b_busy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [7:0] d, input logic stop);
        a_rx = 1'b0;
        repeat (CD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            a_rx = d[i];
            repeat (CD) @(negedge clk);
        end
        a_rx = stop;
        repeat (CD) @(negedge clk);
        a_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int lv[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        logic [7:0] bw[4] = '{8'h00, 8'hFF, 8'h55, 8'h80};
        int busy_n;
        int n;
        int low_n;

        ia.tx_data = '0; ia.tx_valid = 1'b0; ia.rx_ready = 1'b0;
        ib.tx_data = '0; ib.tx_valid = 1'b0; ib.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {a_tx, a_busy, ia.tx_ready, ia.rx_valid, a_fe, a_pe, a_ov}, 7'b1010000);
        check("reset_rx_data", ia.rx_data, 8'h00);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 frame of 0xA5
        ia.tx_data = 8'hA5; ia.tx_valid = 1'b1;
        busy_n = 0;
        for (int i = 1; i <= 220; i++) begin
            @(negedge clk);
            if (i == 1) ia.tx_valid = 1'b0;
            if (a_busy) busy_n++;
            if (i == 2) check("tx_latency_high", a_tx, 1);
            if (i == 3) check("tx_latency_low", a_tx, 0);
            if (i >= 3 && ((i-3) % CD) == CD/2 && ((i-3) / CD) < 10)
                check("tx_bit_level", a_tx, lv[(i-3)/CD]);
        end
        check("tx_busy_cycles", busy_n, 160);

        // Fill the TX FIFO: one word into the shifter, four queued
        for (int k = 0; k < 5; k++) begin
            ia.tx_data = 8'(k + 1); ia.tx_valid = 1'b1;
            check("tx_ready_accept", ia.tx_ready, 1);
            @(negedge clk);
        end
        ia.tx_data = 8'h06;
        check("tx_ready_full", ia.tx_ready, 0);
        n = 0;
        while (!ia.tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("tx6_held_one_frame", (n >= 150 && n <= 200), 1);
        @(negedge clk);
        ia.tx_valid = 1'b0;

        // Reset in the middle of a frame
        repeat (50) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_frame", {a_tx, ia.tx_ready, a_busy}, 3'b110);
        @(negedge clk);
        rst = 1'b1;
        low_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!a_tx || a_busy) low_n++;
        end
        check("tx_fifo_empty_after_rst", low_n, 0);

        // Framing error then a good frame
        send_a(8'h3C, 1'b0);
        check("frame_err_set", {a_fe, a_pe, a_ov, ia.rx_valid}, 4'b1000);
        send_a(8'h11, 1'b1);
        check("rx_after_ferr_valid", ia.rx_valid, 1);
        check("rx_after_ferr_data", ia.rx_data, 8'h11);
        ia.rx_ready = 1'b1;
        @(negedge clk);
        ia.rx_ready = 1'b0;
        check("rx_pop_empty", ia.rx_valid, 0);
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        check("frame_err_clr", a_fe, 0);

        // Overrun: five frames into a four-deep FIFO
        for (int k = 1; k <= 5; k++) send_a(8'(k), 1'b1);
        check("overrun_set", {a_ov, ia.rx_valid, a_fe, a_pe}, 4'b1100);
        for (int i = 0; i < 4; i++) begin
            check("overrun_pop_data", ia.rx_data, i + 1);
            ia.rx_ready = 1'b1;
            @(negedge clk);
            ia.rx_ready = 1'b0;
        end
        check("overrun_no_fifth", ia.rx_valid, 0);
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;

        // Short low glitch is rejected
        a_rx = 1'b0;
        repeat (4) @(negedge clk);
        a_rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_ignored", {ia.rx_valid, a_fe, a_pe, a_ov}, 4'b0000);

        // Even-parity loopback, back-to-back frames
        for (int k = 0; k < 4; k++) begin
            ib.tx_data = bw[k]; ib.tx_valid = 1'b1;
            @(negedge clk);
        end
        ib.tx_valid = 1'b0;
        repeat (760) @(negedge clk);
        check("loop_busy_cycles", b_busy_cyc, 4 * 11 * CD);
        check("loop_no_gap", b_busy_rise, 1);
        check("loop_flags", {b_fe, b_pe, b_ov, b_tx}, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            check("loop_rx_valid", ib.rx_valid, 1);
            check("loop_rx_data", ib.rx_data, bw[k]);
            ib.rx_ready = 1'b1;
            @(negedge clk);
            ib.rx_ready = 1'b0;
        end
        check("loop_rx_drained", ib.rx_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_core_fifo.md
Name: uart_core_fifo

Overview:
Parametrised full-duplex UART core, successor to the fixed 8-bit TX/RX pairing. It adds configurable bit divisor, data width, parity and stop bits, plus TX and RX FIFOs with ready/valid handshakes. It also adds sticky framing, parity and overrun error flags. It sits between the byte-stream logic of the hasher datapath and the board serial pins.

Parameters:
CLK_DIV, 16, clock cycles per serial bit (≥4, even)
DATA_BITS, 8, data bits per frame (5..9)
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits transmitted (1 or 2); RX checks the first stop bit only
FIFO_DEPTH, 4, entries per FIFO (power of 2, ≥2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
rx  input  1  serial in, asynchronous to clk
tx  output  1  serial out, idles high
tx_data  input  DATA_BITS  word to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  TX FIFO not full
tx_busy  output  1  frame currently on the line
rx_data  output  DATA_BITS  head of RX FIFO (show-ahead)
rx_valid  output  1  RX FIFO not empty
rx_ready  input  1  consumer pops the head word
rx_frame_err  output  1  sticky: stop bit sampled 0
rx_parity_err  output  1  sticky: parity mismatch
rx_overrun  output  1  sticky: good frame dropped because RX FIFO full
err_clr  input  1  synchronous clear of all three sticky flags

Behaviour:
- Reset (rst=0, asynchronous) values:
  - tx=1, tx_busy=0, tx_ready=1, rx_valid=0, rx_data=0, all error flags 0.
  - Both FIFOs empty; both FSMs in IDLE. Any in-flight frame is abandoned.
- Handshakes:
  - TX push when tx_valid & tx_ready.
  - RX pop when rx_valid & rx_ready.
  - rx_data is valid whenever rx_valid=1.
- TX FSM, states IDLE → START → DATA → PARITY (skipped if PARITY=0) → STOP → IDLE:
  - In IDLE with FIFO non-empty: pop the head into the shifter; tx goes low on the next clock.
  - A push into an empty FIFO while IDLE gives tx low 2 cycles after the push edge.
  - Each bit lasts exactly CLK_DIV cycles. Data is sent LSB first.
  - Parity bit is the XOR of the data bits: inverted for odd parity, as-is for even.
  - STOP holds tx=1 for STOP_BITS×CLK_DIV cycles.
  - From STOP, if the FIFO is non-empty, go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
  - tx_busy=1 from the first START cycle through the last STOP cycle.
- RX input conditioning:
  - rx passes through a 2-flop synchroniser (reset value 1). All RX timing is relative to the synchronised signal.
- RX FSM, states IDLE → START → DATA → PARITY → STOP → (WAIT_HIGH) → IDLE:
  - IDLE: a synchronised low starts the bit counter.
  - START: at count CLK_DIV/2, re-sample. If the line is high it was a false start: return to IDLE, no flags set.
  - DATA/PARITY/STOP: sample every CLK_DIV cycles from the start-bit midpoint.
  - Stop sampled 0: set rx_frame_err, discard the word, enter WAIT_HIGH until the line returns to 1.
  - Parity mismatch: set rx_parity_err, discard the word.
  - Good frame: written to the RX FIFO in the cycle after the stop-bit sample.
  - FIFO full at write time: set rx_overrun, drop the new word, keep the FIFO contents.
  - Full FIFO with a pop in the same cycle as the write: the write is accepted, no overrun.
- Error flags:
  - Set in the cycle the error is detected; hold until err_clr=1.
  - If err_clr and a new error occur in the same cycle, the set wins.
- FIFOs:
  - Circular buffer with a pointer extended by 1 bit for full/empty.
  - Simultaneous push and pop on a non-empty FIFO keeps the occupancy unchanged.
  - Pushes when full are ignored. tx_ready is combinational from the TX FIFO full flag.
- Frame length:
  - Data bits are DATA_BITS wide; parity adds one bit when PARITY≠0.
  - Total frame = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bits.

Test Plan:
- Defaults (16, 8N1): push 0xA5 → tx levels 0,1,0,1,0,0,1,0,1,1, each held 16 cycles. tx_busy high for 160 cycles; tx low 2 cycles after the push.
- PARITY=2, tx looped to rx: send 0x00, 0xFF, 0x55, 0x80 back-to-back → rx_data sequence identical; tx has no idle gap between frames; all error flags 0.
- Push 6 words with no pops on the line side → the first is taken into the shifter and 4 fill the FIFO. tx_ready goes 0 after the 5th accept; the 6th is held until one frame completes.
- Drive an 8N1 frame of 0x3C with the stop bit low → rx_frame_err=1, rx_valid stays 0. The next valid frame 0x11 is received correctly. err_clr for one cycle → flag 0.
- rx_ready=0, inject 5 good frames 0x01..0x05 → rx_valid=1 with 4 entries, rx_overrun=1. Pops return 0x01..0x04 and no 0x05.
- rx low for 4 cycles (a glitch) → no frame, no flags. Assert rst mid-TX-frame → tx=1 and tx_ready=1 immediately, TX FIFO empty after release.
